// File: rtl/consec_run_detector.sv
// consec_run_detector: Mealy detector for runs of consecutive identical bits with runtime threshold,
// polarity, overlap mode, valid qualifier and sync clear. Define RUN_MATCH_CNT_EN to add match_cnt.
module consec_run_detector #(
   parameter int MAX_RUN = 15,
   parameter int RUN_W   = 4,
   parameter int CNT_W   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic             inp,
   input  logic             pol,
   input  logic [RUN_W-1:0] thresh,
   input  logic             overlap,
   input  logic             clr,
   output logic             outp,
   output logic             outp_q,
   output logic [RUN_W-1:0] run_len
`ifdef RUN_MATCH_CNT_EN
   ,
   output logic [CNT_W-1:0] match_cnt
`endif
);

   localparam logic [RUN_W-1:0] MAX_V  = RUN_W'(MAX_RUN);
   localparam logic [RUN_W-1:0] ZERO_V = {RUN_W{1'b0}};

   logic [RUN_W-1:0] r_run_len;
   logic             r_outp_q;
   logic             w_hit_bit;
   logic [RUN_W-1:0] w_t_eff;
   logic [RUN_W-1:0] w_nxt;
   logic             w_cond;
   logic             w_outp;
   logic [RUN_W-1:0] w_run_nxt;

   // Hit decode: saturated next length compared against the clamped threshold.
   always_comb begin
      w_hit_bit = in_valid & (inp == pol);
      w_t_eff   = (thresh > MAX_V) ? MAX_V : thresh;
      w_nxt     = (r_run_len >= MAX_V) ? MAX_V : (r_run_len + {{(RUN_W-1){1'b0}}, 1'b1});
      if (overlap) begin
         w_cond = (w_nxt >= w_t_eff);
      end else begin
         w_cond = (w_nxt == w_t_eff);
      end
      w_outp = rst & ~clr & w_hit_bit & (w_t_eff != ZERO_V) & w_cond;
   end

   // Run length next-state, clr first, then valid gating, mismatch and restart-after-hit.
   always_comb begin
      w_run_nxt = r_run_len;
      if (clr) begin
         w_run_nxt = ZERO_V;
      end else if (!in_valid) begin
         w_run_nxt = r_run_len;
      end else if (inp != pol) begin
         w_run_nxt = ZERO_V;
      end else if (w_outp && !overlap) begin
         w_run_nxt = ZERO_V;
      end else begin
         w_run_nxt = w_nxt;
      end
   end

   // Run length and registered hit.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_run_len <= ZERO_V;
         r_outp_q  <= 1'b0;
      end else begin
         r_run_len <= w_run_nxt;
         r_outp_q  <= w_outp;
      end
   end

`ifdef RUN_MATCH_CNT_EN
   logic [CNT_W-1:0] r_match_cnt;

   // Saturating hit counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_match_cnt <= {CNT_W{1'b0}};
      end else if (clr) begin
         r_match_cnt <= {CNT_W{1'b0}};
      end else if (w_outp && (r_match_cnt != {CNT_W{1'b1}})) begin
         r_match_cnt <= r_match_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         r_match_cnt <= r_match_cnt;
      end
   end

   assign match_cnt = r_match_cnt;
`endif

   assign outp    = w_outp;
   assign outp_q  = r_outp_q;
   assign run_len = r_run_len;

endmodule

// File: tb/tb_consec_run_detector.sv
// Bench for consec_run_detector: directed test-plan sequences plus randomized traffic against an
// integer reference model of the run/hit rules.
module tb_consec_run_detector;

   localparam int MAX_RUN = 15;
   localparam int RUN_W   = 4;
   localparam int CNT_W   = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             inp;
   logic             pol;
   logic [RUN_W-1:0] thresh;
   logic             overlap;
   logic             clr;
   logic             outp;
   logic             outp_q;
   logic [RUN_W-1:0] run_len;
   logic [CNT_W-1:0] match_cnt;

   int checks = 0;
   int errors = 0;

   int m_run  = 0;
   int m_cnt  = 0;
   int m_outq = 0;
   logic o_seen;

   consec_run_detector #(.MAX_RUN(MAX_RUN), .RUN_W(RUN_W), .CNT_W(CNT_W)) dut (
`ifdef RUN_MATCH_CNT_EN
      .match_cnt(match_cnt),
`endif
      .clk(clk), .rst(rst), .in_valid(in_valid), .inp(inp), .pol(pol), .thresh(thresh),
      .overlap(overlap), .clr(clr), .outp(outp), .outp_q(outp_q), .run_len(run_len)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference hit rule, evaluated from the spec definitions with plain integers.
   function automatic int model_hit();
      int t_eff;
      int nxt;
      t_eff = (int'(thresh) > MAX_RUN) ? MAX_RUN : int'(thresh);
      nxt   = (m_run + 1 > MAX_RUN) ? MAX_RUN : m_run + 1;
      if (!rst || clr || !in_valid || (inp != pol) || t_eff == 0) return 0;
      if (overlap) return (nxt >= t_eff) ? 1 : 0;
      return (nxt == t_eff) ? 1 : 0;
   endfunction

   task automatic check_state(input string tag);
      chk({tag, "_run_len"}, 32'(run_len), m_run);
      chk({tag, "_outp_q"}, 32'(outp_q), m_outq);
`ifdef RUN_MATCH_CNT_EN
      chk({tag, "_match_cnt"}, 32'(match_cnt), m_cnt);
`endif
   endtask

   // One clock: drive inputs, check Mealy output, clock, check registered state.
   task automatic step(input logic v, input logic b, input logic c, output logic o);
      int h;
      int nrun;
      int nxt;
      in_valid = v; inp = b; clr = c;
      #1;
      h = model_hit();
      chk("outp", 32'(outp), h);
      o = outp;
      nxt = (m_run + 1 > MAX_RUN) ? MAX_RUN : m_run + 1;
      if (c) nrun = 0;
      else if (!v) nrun = m_run;
      else if (b != pol) nrun = 0;
      else if (h == 1 && !overlap) nrun = 0;
      else nrun = nxt;
      @(posedge clk);
      m_run  = nrun;
      m_outq = h;
      if (c) m_cnt = 0;
      else if (h == 1 && m_cnt < 255) m_cnt = m_cnt + 1;
      #1;
      check_state("step");
   endtask

   task automatic config_clear(input logic [RUN_W-1:0] t, input logic p, input logic ov);
      logic o;
      thresh = t; pol = p; overlap = ov;
      step(1'b0, 1'b0, 1'b1, o);
   endtask

   initial begin
      int t1_run[8];
      int t3_run[6];
      int t4_run[5];
      logic t3_bits[6];
      logic t4_val[5];
      t1_run = '{1, 2, 3, 0, 1, 2, 3, 0};
      t3_run = '{1, 2, 0, 1, 2, 0};
      t3_bits = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      t4_run = '{1, 2, 2, 2, 0};
      t4_val = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

      rst = 1'b0; in_valid = 1'b1; inp = 1'b1; pol = 1'b1; thresh = 4'd1; overlap = 1'b0; clr = 1'b0;
      #3;
      chk("reset_outp", 32'(outp), 0);
      chk("reset_run_len", 32'(run_len), 0);
      chk("reset_outp_q", 32'(outp_q), 0);
      #4;
      rst = 1'b1;
      in_valid = 1'b0;
      @(posedge clk); #1;

      // Non-overlapping, thresh 4.
      config_clear(4'd4, 1'b1, 1'b0);
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 1'b1, 1'b0, o_seen);
         chk("t1_outp", 32'(o_seen), (i == 3 || i == 7) ? 1 : 0);
         chk("t1_run", 32'(run_len), t1_run[i]);
         chk("t1_outp_q", 32'(outp_q), (i == 3 || i == 7) ? 1 : 0);
      end

      // Overlapping, same stream.
      config_clear(4'd4, 1'b1, 1'b1);
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 1'b1, 1'b0, o_seen);
         chk("t2_outp", 32'(o_seen), (i >= 3) ? 1 : 0);
         chk("t2_run", 32'(run_len), i + 1);
      end
`ifdef RUN_MATCH_CNT_EN
      chk("t2_match_cnt", 32'(match_cnt), 5);
`endif

      // Runs of zeros with a mismatch.
      config_clear(4'd3, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) begin
         step(1'b1, t3_bits[i], 1'b0, o_seen);
         chk("t3_outp", 32'(o_seen), (i == 5) ? 1 : 0);
         chk("t3_run", 32'(run_len), t3_run[i]);
      end

      // Valid gap holds the run.
      config_clear(4'd3, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         step(t4_val[i], t4_val[i] ? 1'b1 : 1'($urandom_range(0, 1)), 1'b0, o_seen);
         chk("t4_outp", 32'(o_seen), (i == 4) ? 1 : 0);
         chk("t4_run", 32'(run_len), t4_run[i]);
      end

      // Disabled detection and saturation.
      config_clear(4'd0, 1'b1, 1'b1);
      for (int i = 0; i < 20; i++) begin
         step(1'b1, 1'b1, 1'b0, o_seen);
         chk("t5_outp", 32'(o_seen), 0);
         chk("t5_run", 32'(run_len), (i + 1 > 15) ? 15 : i + 1);
      end

      // Saturated overlap at thresh 15 keeps hitting.
      thresh = 4'd15;
      step(1'b1, 1'b1, 1'b0, o_seen);
      chk("t5_sat_hit", 32'(o_seen), 1);
      step(1'b1, 1'b1, 1'b0, o_seen);
      chk("t5_sat_hit2", 32'(o_seen), 1);

      // Asynchronous reset mid-cycle.
      config_clear(4'd2, 1'b1, 1'b1);
      step(1'b1, 1'b1, 1'b0, o_seen);
      step(1'b1, 1'b1, 1'b0, o_seen);
      chk("t6_pre_outp_q", 32'(outp_q), 1);
      in_valid = 1'b1; inp = 1'b1; clr = 1'b0;
      #1;
      rst = 1'b0;
      #1;
      m_run = 0; m_outq = 0; m_cnt = 0;
      chk("t6_rst_outp", 32'(outp), 0);
      chk("t6_rst_run_len", 32'(run_len), 0);
      chk("t6_rst_outp_q", 32'(outp_q), 0);
`ifdef RUN_MATCH_CNT_EN
      chk("t6_rst_match_cnt", 32'(match_cnt), 0);
`endif
      #1;
      rst = 1'b1;
      step(1'b0, 1'b0, 1'b0, o_seen);

      // clr beats a hitting bit.
      config_clear(4'd2, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0, o_seen);
      chk("t7_pre_run", 32'(run_len), 1);
      step(1'b1, 1'b1, 1'b1, o_seen);
      chk("t7_clr_outp", 32'(o_seen), 0);
      chk("t7_clr_run", 32'(run_len), 0);

      // Randomized traffic against the reference model.
      config_clear(4'd3, 1'b1, 1'b0);
      for (int i = 0; i < 400; i++) begin
         logic v;
         logic b;
         logic c;
         if ($urandom_range(0, 15) == 0) begin
            thresh  = 4'($urandom_range(0, 15));
            pol     = 1'($urandom_range(0, 1));
            overlap = 1'($urandom_range(0, 1));
         end
         c = ($urandom_range(0, 24) == 0);
         v = ($urandom_range(0, 3) != 0);
         b = ($urandom_range(0, 5) != 0) ? pol : ~pol;
         step(v, b, c, o_seen);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/consec_run_detector.md
Name: consec_run_detector

Overview:
- Parametrised Mealy detector for runs of consecutive identical bits on a serial input.
- Next generation of the fixed four-ones detector, with these additions:
  - runtime run-length threshold;
  - selectable bit polarity;
  - overlapping or restarting match mode;
  - valid qualifier and synchronous clear.
- Sits on the serial bit path after the sampler.
- Outputs an immediate Mealy pulse plus a registered copy for downstream sequential logic.

Parameters:
- MAX_RUN, 15: largest run length tracked; the run counter saturates here.
- RUN_W, 4: width of thresh and run_len; must satisfy 2^RUN_W > MAX_RUN.
- CNT_W, 8: width of match_cnt (optional feature only).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset (rst=0 resets).
- in_valid  in  1  qualifies inp; state advances only when 1.
- inp  in  1  serial data bit.
- pol  in  1  bit value being counted (1 = runs of ones, 0 = runs of zeros).
- thresh  in  RUN_W  required run length; 0 = detection disabled.
- overlap  in  1  1 = keep counting after a hit, 0 = restart after a hit.
- clr  in  1  synchronous clear of run state (and match_cnt).
- outp  out  1  Mealy hit, combinational from state and current inputs.
- outp_q  out  1  outp registered (1-cycle latency).
- run_len  out  RUN_W  current registered run length.
- match_cnt  out  CNT_W  hit counter; present only with RUN_MATCH_CNT_EN.

Behaviour:
- Reset (rst=0, asynchronous):
  - run_len=0, outp_q=0, match_cnt=0.
  - outp is forced 0 while rst=0.
- Definitions:
  - hit_bit = in_valid & (inp==pol).
  - t_eff = min(thresh, MAX_RUN).
  - nxt = run_len+1, saturating at MAX_RUN.
- Mealy output: outp = rst & ~clr & hit_bit & (t_eff!=0) & cond, where cond is:
  - overlap=0: nxt==t_eff;
  - overlap=1: nxt>=t_eff.
- Run update at each rising edge, in priority order:
  1. clr=1: run_len<=0.
  2. in_valid=0: run_len holds.
  3. Mismatching bit (inp!=pol): run_len<=0.
  4. hit_bit with outp=1 and overlap=0: run_len<=0 (non-overlapping restart).
  5. Otherwise, on hit_bit: run_len<=nxt.
- Saturation: at run_len==MAX_RUN, further matching bits keep run_len at MAX_RUN.
  - With overlap=1 and t_eff==MAX_RUN, outp stays 1 for every further matching bit.
- Disabled detection (thresh=0): run_len still counts; outp never asserts.
- outp_q <= outp every edge. When in_valid=0, outp=0, so outp_q falls one cycle later.
- Configuration changes (pol, thresh, overlap):
  - take effect combinationally in the same cycle; run_len is not cleared automatically;
  - software issues clr when changing pol.
- Example: with thresh=1 and overlap=0, every matching bit gives a hit and run_len stays 0.
- Simultaneous clr and matching bit: clr wins. outp=0, run_len=0, no count.
- Reset mid-run: all state returns to reset values immediately; no hit is produced from the pre-reset run.

Optional Feature:
- Macro RUN_MATCH_CNT_EN.
- Defined:
  - port match_cnt (CNT_W) exists;
  - it increments by 1 on each edge where outp=1, saturating at 2^CNT_W-1;
  - it is cleared by rst (async) and by clr (sync).
- Undefined:
  - port and counter are absent;
  - all other behaviour is identical.

Test Plan:
- thresh=4, pol=1, overlap=0, in_valid=1, bits 1,1,1,1,1,1,1,1:
  - outp=1 exactly on bits 4 and 8;
  - outp_q=1 one cycle after each;
  - run_len sequence 1,2,3,0,1,2,3,0.
- Same stream with overlap=1:
  - outp=1 on bits 4..8;
  - run_len 1..8;
  - match_cnt=5 when RUN_MATCH_CNT_EN is defined.
- thresh=3, pol=0, bits 0,0,1,0,0,0 (bit 3 is inp=1, a mismatch):
  - run_len resets at bit 3;
  - single outp pulse on bit 6.
- thresh=3, bits 1,1,[in_valid=0 for 2 cycles],1:
  - run_len holds 2 across the gap;
  - outp=1 on the third valid bit.
- MAX_RUN=15, thresh=0, 20 ones:
  - run_len saturates at 15;
  - outp never 1.
- Resets and clr:
  - thresh=2 with run_len=1: drive rst=0 asynchronously mid-cycle; run_len, outp_q and match_cnt go to 0 before the next edge;
  - separately, assert clr together with a matching bit that would hit: outp=0, run_len=0.
